// File: rtl/ceres_plru_ctrl.sv
// ---------------------------------------------------------------------------
// ceres_plru_ctrl
// Per-set tree-PLRU replacement controller for the set-associative caches.
// Each set holds NUM_WAY-1 node bits. Hits/fills move the tree pointer away
// from the touched way. Lookups return a registered one-hot victim, where an
// invalid way takes priority over the PLRU choice. After reset or flush a
// sequential sweep clears one set per cycle.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           pulse: restart the clearing sweep at set 0
//   busy_o            sweep in progress (lookups/accesses ignored)
//   lookup_valid_i    victim query for set lookup_idx_i, way-valid bits valid_vec_i
//   victim_valid_o    1-cycle pulse, victim_way_o is one-hot (held otherwise)
//   access_valid_i    hit/fill touch of access_way_i in set access_idx_i
// ---------------------------------------------------------------------------
module ceres_plru_ctrl #(
  parameter int  NUM_WAY = 4,
  parameter int  NUM_SET = 64,
  localparam int IDX_W   = $clog2(NUM_SET)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  output logic               busy_o,
  input  logic               lookup_valid_i,
  input  logic [IDX_W-1:0]   lookup_idx_i,
  input  logic [NUM_WAY-1:0] valid_vec_i,
  output logic               victim_valid_o,
  output logic [NUM_WAY-1:0] victim_way_o,
  input  logic               access_valid_i,
  input  logic [IDX_W-1:0]   access_idx_i,
  input  logic [NUM_WAY-1:0] access_way_i
);

  localparam int L  = $clog2(NUM_WAY);
  localparam int NN = NUM_WAY - 1;

  if (NUM_WAY < 2 || (NUM_WAY & (NUM_WAY - 1)) != 0) begin : g_bad_way
    $error("ceres_plru_ctrl: NUM_WAY must be a power of 2 and >= 2");
  end
  if (NUM_SET < 2 || (NUM_SET & (NUM_SET - 1)) != 0) begin : g_bad_set
    $error("ceres_plru_ctrl: NUM_SET must be a power of 2 and >= 2");
  end

  typedef logic [NN-1:0] node_t;
  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  // Point every node on the path of the lowest set way bit away from it.
  function automatic node_t touch(input node_t nodes, input logic [NUM_WAY-1:0] way);
    int w, n;
    w = 0;
    for (int k = NUM_WAY - 1; k >= 0; k--)
      if (way[k[L-1:0]]) w = k;
    for (int lvl = 0; lvl < L; lvl++) begin
      n = ((1 << lvl) - 1) + (w >> (L - lvl));
      nodes[n[L-1:0]] = (((w >> (L - lvl - 1)) & 1) == 0);
    end
    return nodes;
  endfunction

  // Lowest invalid way wins; otherwise follow the node bits from the root.
  function automatic logic [NUM_WAY-1:0] pick(input node_t nodes, input logic [NUM_WAY-1:0] vld);
    int i, n;
    logic hole;
    logic [NUM_WAY-1:0] oh;
    hole = 1'b0;
    i    = 0;
    for (int k = NUM_WAY - 1; k >= 0; k--)
      if (!vld[k[L-1:0]]) begin
        hole = 1'b1;
        i    = k;
      end
    if (!hole) begin
      i = 0;
      for (int lvl = 0; lvl < L; lvl++) begin
        n = ((1 << lvl) - 1) + i;
        i = 2 * i + (nodes[n[L-1:0]] ? 1 : 0);
      end
    end
    oh = '0;
    oh[i[L-1:0]] = 1'b1;
    return oh;
  endfunction

  state_e               state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 vld_q;
  logic [NUM_WAY-1:0]   way_q;
  node_t                mem_q [NUM_SET];

  logic                 idle, acc_en, lk_en;
  node_t                acc_nodes, lk_nodes;
  logic [NUM_WAY-1:0]   victim_d;

  // The flush cycle itself already drops traffic.
  assign idle   = (state_q == S_IDLE) && !flush_i;
  assign acc_en = idle && access_valid_i && (|access_way_i);
  assign lk_en  = idle && lookup_valid_i;

  assign acc_nodes = touch(mem_q[access_idx_i], access_way_i);
  // Same-set access in the lookup cycle: victim sees the post-update bits.
  assign lk_nodes  = (acc_en && access_idx_i == lookup_idx_i) ? acc_nodes
                                                              : mem_q[lookup_idx_i];
  assign victim_d  = pick(lk_nodes, valid_vec_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_CLEAR) mem_q[ptr_q] <= '0;
      else if (acc_en)        mem_q[access_idx_i] <= acc_nodes;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      way_q   <= '0;
    end else begin
      vld_q <= lk_en;
      if (lk_en) way_q <= victim_d;
      case (state_q)
        S_CLEAR: begin
          if (flush_i) ptr_q <= '0;
          else begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == IDX_W'(NUM_SET - 1)) state_q <= S_IDLE;
          end
        end
        default: begin
          if (flush_i) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
          end
        end
      endcase
    end
  end

  assign busy_o         = (state_q == S_CLEAR);
  assign victim_valid_o = vld_q;
  assign victim_way_o   = way_q;

endmodule

// File: tb/tb_ceres_plru_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ceres_plru_ctrl
// Scoreboard bench: the driver pushes expected victims as lookups are issued;
// a negedge monitor pops and compares whenever victim_valid_o is high. The
// reference keeps per-set node bits and finds the victim by searching all
// ways for the one whose whole path matches the node bits.
// ---------------------------------------------------------------------------
module tb_ceres_plru_ctrl;
  localparam int NW = 4;
  localparam int NS = 64;
  localparam int L  = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       busy_o;
  logic       lookup_valid_i = 1'b0;
  logic [5:0] lookup_idx_i = '0;
  logic [3:0] valid_vec_i = '0;
  logic       victim_valid_o;
  logic [3:0] victim_way_o;
  logic       access_valid_i = 1'b0;
  logic [5:0] access_idx_i = '0;
  logic [3:0] access_way_i = '0;

  ceres_plru_ctrl #(.NUM_WAY(NW), .NUM_SET(NS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .busy_o(busy_o),
    .lookup_valid_i(lookup_valid_i), .lookup_idx_i(lookup_idx_i),
    .valid_vec_i(valid_vec_i), .victim_valid_o(victim_valid_o),
    .victim_way_o(victim_way_o), .access_valid_i(access_valid_i),
    .access_idx_i(access_idx_i), .access_way_i(access_way_i)
  );

  always #5 clk_i = ~clk_i;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  bit         mnodes[NS][NW-1];
  bit         mbusy = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void mclear();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NW - 1; n++) mnodes[s][n] = 1'b0;
  endfunction

  function automatic void mtouch(input int s, input logic [3:0] wv);
    int w, n, dir;
    if (wv == 4'b0) return;
    w = 0;
    for (int i = NW - 1; i >= 0; i--) if (wv[i]) w = i;
    for (int lvl = 0; lvl < L; lvl++) begin
      n   = (2 ** lvl - 1) + (w >> (L - lvl));
      dir = (w >> (L - lvl - 1)) & 1;
      mnodes[s][n] = (dir == 0);
    end
  endfunction

  function automatic logic [3:0] mvictim(input int s, input logic [3:0] vv);
    logic [3:0] r;
    bit ok;
    int n, dir;
    r = 4'b0;
    for (int i = NW - 1; i >= 0; i--) if (!vv[i]) r = 4'(1 << i);
    if (r != 4'b0) return r;
    for (int i = 0; i < NW; i++) begin
      ok = 1'b1;
      for (int lvl = 0; lvl < L; lvl++) begin
        n   = (2 ** lvl - 1) + (i >> (L - lvl));
        dir = (i >> (L - lvl - 1)) & 1;
        if (mnodes[s][n] != dir[0]) ok = 1'b0;
      end
      if (ok) r = 4'(1 << i);
    end
    return r;
  endfunction

  // One cycle of stimulus; exp_const < 0 means "use the reference model".
  task automatic step(input bit lv, input int li, input logic [3:0] vv,
                      input bit av, input int ai, input logic [3:0] aw,
                      input bit fl, input int exp_const);
    lookup_valid_i = lv;  lookup_idx_i = li[5:0]; valid_vec_i = vv;
    access_valid_i = av;  access_idx_i = ai[5:0]; access_way_i = aw;
    flush_i = fl;
    if (fl) begin
      mbusy = 1'b1;
      mclear();
    end else if (!mbusy) begin
      if (av) mtouch(ai, aw);
      if (lv) exp_q.push_back(exp_const >= 0 ? exp_const[3:0] : mvictim(li, vv));
    end
    @(posedge clk_i); #1;
    lookup_valid_i = 1'b0; access_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic rand_step(input int set_hi);
    logic [3:0] vv;
    vv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
    step($urandom_range(0, 1) == 1, $urandom_range(0, set_hi), vv,
         $urandom_range(0, 2) != 0, $urandom_range(0, set_hi), 4'($urandom), 1'b0, -1);
  endtask

  // Count busy cycles (with traffic that must be dropped) until idle.
  task automatic wait_busy(input string name);
    int cnt;
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 200) begin
      cnt++;
      rand_step(NS - 1);
    end
    chk(name, cnt, 64);
    mbusy = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (victim_valid_o === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_victim", 32'(victim_way_o), 32'hDEAD);
      else chk("victim", 32'(victim_way_o), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    mclear();
    // 1. reset, sweep length, cleared victim
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_valid", 32'(victim_valid_o), 0);
    chk("rst_way", 32'(victim_way_o), 0);
    wait_busy("rst_busy_len");
    step(1, 7, 4'hF, 0, 0, 4'h0, 0, 4'b0001);

    // 2. touch all ways of set 5 in order, then way 0
    for (int w = 0; w < 4; w++) step(0, 0, 4'hF, 1, 5, 4'(1 << w), 0, -1);
    step(1, 5, 4'hF, 0, 0, 4'h0, 0, 4'b0001);
    step(0, 0, 4'hF, 1, 5, 4'b0001, 0, -1);
    step(1, 5, 4'hF, 0, 0, 4'h0, 0, 4'b0100);

    // 3. invalid way priority
    step(0, 0, 4'hF, 1, 9, 4'b0100, 0, -1);
    step(1, 9, 4'b1011, 0, 0, 4'h0, 0, 4'b0100);
    step(1, 9, 4'b0000, 0, 0, 4'h0, 0, 4'b0001);

    // 4. same-cycle bypass vs different set
    step(1, 3, 4'hF, 1, 3, 4'b0001, 0, 4'b0100);
    step(1, 11, 4'hF, 1, 4, 4'b0001, 0, 4'b0001);

    // 6. multi-bit and zero access vectors
    step(0, 0, 4'hF, 1, 20, 4'b0010, 0, -1);
    step(1, 20, 4'hF, 0, 0, 4'h0, 0, 4'b0100);
    step(0, 0, 4'hF, 1, 21, 4'b0110, 0, -1);
    step(1, 21, 4'hF, 0, 0, 4'h0, 0, 4'b0100);
    step(0, 0, 4'hF, 1, 21, 4'b0000, 0, -1);
    step(1, 21, 4'hF, 0, 0, 4'h0, 0, 4'b0100);

    // random traffic against the model, concentrated on a few sets
    repeat (300) rand_step(7);

    // 5. flush, re-flush mid-sweep, everything cleared afterwards
    step(1, 2, 4'hF, 1, 2, 4'b1000, 1, -1);
    for (int k = 0; k < 30; k++) begin
      chk("flush_busy", 32'(busy_o), 1);
      rand_step(NS - 1);
    end
    step(1, 2, 4'hF, 1, 2, 4'b1000, 1, -1);
    wait_busy("reflush_busy_len");
    for (int s = 0; s < NS; s++) step(1, s, 4'hF, 0, 0, 4'h0, 0, 4'b0001);

    repeat (400) rand_step(15);

    repeat (3) step(0, 0, 4'hF, 0, 0, 4'h0, 0, -1);
    chk("drain", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
